// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared constants and types for the VGA framebuffer path.
//
// Contents:
//   H_VISIBLE, H_TOTAL   : horizontal timing (pixels per line)
//   V_VISIBLE, V_TOTAL   : vertical timing (lines per frame)
//   FB_SCALE_LOG2        : log2 of the pixel replication factor (4x4 blocks)
//   rgb332_t             : packed 8-bit colour {r[2:0], g[2:0], b[1:0]}
//   next_line()          : vertical counter successor with frame wrap
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VISIBLE     = 640;
    localparam int H_TOTAL       = 800;
    localparam int V_VISIBLE     = 480;
    localparam int V_TOTAL       = 525;
    localparam int FB_SCALE_LOG2 = 2;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Line number that follows vc, wrapping from the last line back to 0.
    function automatic logic [9:0] next_line(input logic [9:0] vc);
        if (vc == 10'(V_TOTAL - 1)) begin
            return 10'd0;
        end
        return vc + 10'd1;
    endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// -----------------------------------------------------------------------------
// vga_fb_addr_gen
//
// Decides which RAM cycles belong to the display fetch and produces the
// framebuffer byte address for each fetch. Owns the row_base running sum.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   synchronous active-high reset
//   hc         in   horizontal counter 0..799
//   vc         in   vertical counter 0..524
//   fetch_slot out  this cycle is reserved for a display read
//   fetch_addr out  byte address to read when fetch_slot is high
// -----------------------------------------------------------------------------
module vga_fb_addr_gen
    import vga_pkg::*;
#(
    parameter int FB_W   = 160,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    output logic              fetch_slot,
    output logic [ADDR_W-1:0] fetch_addr
);

    // Last in-line fetch targets the final group of the line (tx = 636),
    // issued two pixels early so the read data lands in time.
    localparam logic [9:0] LAST_SLOT_HC   = 10'(H_VISIBLE - (1 << FB_SCALE_LOG2) - 2);
    localparam logic [9:0] LINE_FETCH_HC  = 10'(H_TOTAL - 2);
    localparam logic [9:0] ROW_UPDATE_HC  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS          = 10'(V_VISIBLE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

    logic [9:0]        nl;
    logic              in_line_slot;
    logic              line_start_slot;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_next;
    logic [ADDR_W-1:0] group_next;

    always_comb begin
        nl              = next_line(vc);
        in_line_slot    = (hc[1:0] == 2'd2) && (hc <= LAST_SLOT_HC) && (vc < V_VIS);
        line_start_slot = (hc == LINE_FETCH_HC) && (nl < V_VIS);
        fetch_slot      = in_line_slot || line_start_slot;
    end

    // Row base for the upcoming line. A framebuffer row spans four screen
    // lines, so the base only advances when the next line starts a new row.
    always_comb begin
        row_base_next = row_base;
        if (nl == 10'd0) begin
            row_base_next = '0;
        end else if (nl[FB_SCALE_LOG2-1:0] == '0) begin
            row_base_next = row_base + ROW_STEP;
        end
    end

    // In-line fetches read group (hc+2)>>2, which equals hc>>2 plus one
    // because hc[1:0] is 2 in every in-line slot. The end-of-line fetch
    // already belongs to the next line, so it uses the next row base
    // before the register catches up at hc=799.
    always_comb begin
        group_next = ADDR_W'(hc[9:FB_SCALE_LOG2]) + ADDR_W'(1);
        if (line_start_slot) begin
            fetch_addr = row_base_next;
        end else begin
            fetch_addr = row_base + group_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (hc == ROW_UPDATE_HC) begin
            row_base <= row_base_next;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares a single-port 8-bit framebuffer RAM (FB_W x FB_H, shown at 4x4
// scaling) between the VGA display fetch and a drawing-side writer. Display
// reads always win; the writer is granted every remaining RAM cycle.
//
// Optional build macro:
//   VGA_FB_VBLANK_WR_EN  when defined, writes are granted only during
//                        vertical blanking (vc >= 480) for tear-free updates.
//
// Ports:
//   vgaclk     in   pixel clock
//   rst        in   synchronous active-high reset
//   hc, vc     in   VGA timing counters
//   wr_valid   in   writer request
//   wr_ready   out  writer grant for this cycle (independent of wr_valid)
//   wr_addr    in   writer byte address (row*FB_W + col)
//   wr_data    in   writer colour, RGB332
//   mem_addr   out  RAM address
//   mem_we     out  RAM write enable
//   mem_wdata  out  RAM write data
//   mem_rdata  in   RAM read data, one cycle after its address
//   pix_red    out  registered pixel red
//   pix_green  out  registered pixel green
//   pix_blue   out  registered pixel blue
// -----------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15
) (
    input  logic              vgaclk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [2:0]        pix_red,
    output logic [2:0]        pix_green,
    output logic [1:0]        pix_blue
);

    // One extra bit so the bound is representable even when the
    // framebuffer exactly fills the address space.
    localparam logic [ADDR_W:0] FB_BYTES = (ADDR_W + 1)'(FB_W * FB_H);

    logic              fetch_slot;
    logic [ADDR_W-1:0] fetch_addr;
    logic              wr_window;
    logic              wr_fire;
    logic              wr_in_range;
    logic              rd_pend;
    rgb332_t           pix_q;

    vga_fb_addr_gen #(
        .FB_W   (FB_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (vgaclk),
        .rst        (rst),
        .hc         (hc),
        .vc         (vc),
        .fetch_slot (fetch_slot),
        .fetch_addr (fetch_addr)
    );

`ifdef VGA_FB_VBLANK_WR_EN
    always_comb wr_window = (vc >= 10'(V_VISIBLE));
`else
    always_comb wr_window = 1'b1;
`endif

    // Grant depends only on timing and reset, so a writer can never
    // create a combinational loop through wr_valid.
    always_comb begin
        wr_ready    = !rst && !fetch_slot && wr_window;
        wr_fire     = wr_valid && wr_ready;
        wr_in_range = ({1'b0, wr_addr} < FB_BYTES);
    end

    // Out-of-range writes still complete the handshake but never reach
    // the RAM write port.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (fetch_slot) begin
            mem_addr = fetch_addr;
        end else if (wr_fire) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_we    = wr_in_range;
        end
    end

    // rd_pend marks the cycle in which the RAM returns fetched data; the
    // colour is captured at the end of that cycle so group g appears on
    // the outputs exactly during hc = 4g..4g+3.
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            pix_q   <= '0;
        end else begin
            rd_pend <= fetch_slot;
            if (rd_pend) begin
                pix_q <= rgb332_t'(mem_rdata);
            end
        end
    end

    always_comb begin
        pix_red   = pix_q.r;
        pix_green = pix_q.g;
        pix_blue  = pix_q.b;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Directed bench for vga_fb_arbiter with a behavioural synchronous RAM.
// The VGA counters are driven by the bench and jumped between regions of
// interest to keep runs short; the design resynchronises at line 0.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int ADDR_W = 15;

    logic              vgaclk;
    logic              rst;
    logic [9:0]        hc;
    logic [9:0]        vc;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [2:0]        pix_red;
    logic [2:0]        pix_green;
    logic [1:0]        pix_blue;

    logic [7:0] ram [0:(1<<ADDR_W)-1];

    int total;
    int bad;

    vga_fb_arbiter #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_red   (pix_red),
        .pix_green (pix_green),
        .pix_blue  (pix_blue)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    // Single-port synchronous RAM, read data one cycle after address.
    always @(posedge vgaclk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Advance the timing counters by one pixel just after the clock edge.
    task automatic tick();
        @(posedge vgaclk);
        #1;
        if (hc == 10'd799) begin
            hc = 10'd0;
            vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
        end else begin
            hc = hc + 10'd1;
        end
        #1;
    endtask

    task automatic goto_pos(input int h, input int v);
        hc = 10'(h);
        vc = 10'(v);
        #1;
    endtask

    task automatic test_reset();
        logic exp_ready;
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 15'd100;
        wr_data  = 8'h12;
        goto_pos(5, 0);
        repeat (3) begin
            tick();
            total++;
            if ({pix_red, pix_green, pix_blue} !== 8'h00) begin
                bad++;
                $display("[TB] FAIL reset_pix got=%h want=00", {pix_red, pix_green, pix_blue});
            end
            total++;
            if (wr_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_ready got=%b want=0", wr_ready);
            end
            total++;
            if (mem_we !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_we got=%b want=0", mem_we);
            end
        end
        rst      = 1'b0;
        wr_valid = 1'b0;
        #1;
        // hc=8 is not a fetch slot
`ifdef VGA_FB_VBLANK_WR_EN
        exp_ready = 1'b0;
`else
        exp_ready = 1'b1;
`endif
        total++;
        if (wr_ready !== exp_ready) begin
            bad++;
            $display("[TB] FAIL release_ready hc=%0d got=%b want=%b", hc, wr_ready, exp_ready);
        end
    endtask

    // Walks lines 0..7 of a frame and checks the first four pixel groups.
    task automatic run_frame(input bit with_e0, input string tag);
        int         addr;
        logic [7:0] exp_b;
        goto_pos(796, 524);
        repeat (4) tick();
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 16; h++) begin
                addr  = (v / 4) * FB_W + (h / 4);
                exp_b = addr[7:0];
                if (with_e0 && addr == 161) exp_b = 8'hE0;
                total++;
                if ({pix_red, pix_green, pix_blue} !== exp_b) begin
                    bad++;
                    $display("[TB] FAIL %s_pix v=%0d h=%0d got=%h want=%h",
                             tag, v, h, {pix_red, pix_green, pix_blue}, exp_b);
                end
                if (h == 2) begin
                    total++;
                    if (mem_addr !== 15'((v / 4) * FB_W + 1) || mem_we !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL %s_fetch_addr v=%0d got=%0d/%b want=%0d/0",
                                 tag, v, mem_addr, mem_we, (v / 4) * FB_W + 1);
                    end
                end
                tick();
            end
            if (v < 7) begin
                goto_pos(796, v);
                repeat (4) tick();
            end
        end
    endtask

    task automatic test_write_stall();
        logic exp_ready;
        int   acc;
        int   wes;
        int   exp_cnt;
        acc = 0;
        wes = 0;
        goto_pos(0, 10);
        wr_valid = 1'b1;
        wr_addr  = 15'd19000;
        wr_data  = 8'h55;
        #1;
        for (int i = 0; i < 800; i++) begin
`ifdef VGA_FB_VBLANK_WR_EN
            exp_ready = 1'b0;
`else
            exp_ready = !(((hc[1:0] == 2'd2) && (hc <= 10'd634)) || (hc == 10'd798));
`endif
            total++;
            if (wr_ready !== exp_ready) begin
                bad++;
                $display("[TB] FAIL stall_ready hc=%0d got=%b want=%b", hc, wr_ready, exp_ready);
            end
            if (wr_ready === 1'b1) acc++;
            if (mem_we === 1'b1) wes++;
            tick();
        end
        wr_valid = 1'b0;
        #1;
`ifdef VGA_FB_VBLANK_WR_EN
        exp_cnt = 0;
`else
        exp_cnt = 640;
`endif
        total++;
        if (acc != exp_cnt) begin
            bad++;
            $display("[TB] FAIL stall_accepts got=%0d want=%0d", acc, exp_cnt);
        end
        total++;
        if (wes != exp_cnt) begin
            bad++;
            $display("[TB] FAIL stall_writes got=%0d want=%0d", wes, exp_cnt);
        end
    endtask

    task automatic test_blank_write();
        goto_pos(101, 500);
        wr_valid = 1'b1;
        wr_addr  = 15'd161;
        wr_data  = 8'hE0;
        #1;
        total++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd161 || mem_wdata !== 8'hE0) begin
            bad++;
            $display("[TB] FAIL blank_write got=%b/%b/%0d/%h want=1/1/161/e0",
                     wr_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        wr_valid = 1'b0;
        #1;
        total++;
        if (ram[161] !== 8'hE0) begin
            bad++;
            $display("[TB] FAIL blank_ram got=%h want=e0", ram[161]);
        end
    endtask

    task automatic test_out_of_range();
        goto_pos(103, 500);
        wr_valid = 1'b1;
        wr_addr  = 15'd19200;
        wr_data  = 8'hFF;
        #1;
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL oor_ready got=%b want=1", wr_ready);
        end
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL oor_we got=%b want=0", mem_we);
        end
        tick();
        wr_valid = 1'b0;
        #1;
        total++;
        if (ram[19200] !== 8'h00) begin
            bad++;
            $display("[TB] FAIL oor_ram got=%h want=00", ram[19200]);
        end
    endtask

    task automatic test_mid_reset();
        goto_pos(300, 200);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_ready0 got=%b want=0", wr_ready);
        end
        repeat (3) begin
            tick();
            total++;
            if ({pix_red, pix_green, pix_blue} !== 8'h00 || wr_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrst_hold pix=%h ready=%b want=00/0",
                         {pix_red, pix_green, pix_blue}, wr_ready);
            end
        end
        rst = 1'b0;
        repeat (10) tick();
        run_frame(1'b1, "post_reset");
    endtask

    task automatic test_vblank_gate();
        logic exp_ready;
        goto_pos(790, 479);
        for (int i = 0; i < 11; i++) begin
`ifdef VGA_FB_VBLANK_WR_EN
            exp_ready = (vc >= 10'd480);
`else
            exp_ready = 1'b1;
`endif
            total++;
            if (wr_ready !== exp_ready) begin
                bad++;
                $display("[TB] FAIL vblank_ready v=%0d h=%0d got=%b want=%b", vc, hc, wr_ready, exp_ready);
            end
            tick();
        end
        // Line-0 fetch at the very end of the frame still blocks the writer.
        goto_pos(797, 524);
        for (int i = 0; i < 3; i++) begin
            exp_ready = (hc != 10'd798);
            total++;
            if (wr_ready !== exp_ready) begin
                bad++;
                $display("[TB] FAIL frame_end_ready h=%0d got=%b want=%b", hc, wr_ready, exp_ready);
            end
            tick();
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        hc       = 10'd0;
        vc       = 10'd0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int k = 0; k < (1 << ADDR_W); k++) begin
            ram[k] = 8'(k);
        end

        test_reset();
        run_frame(1'b0, "frame1");
        test_write_stall();
        test_blank_write();
        test_out_of_range();
        run_frame(1'b1, "frame2");
        test_mid_reset();
        test_vblank_gate();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port 8-bit framebuffer RAM (160x120, 4x4 pixel scaling) between two users: the VGA display fetch and a drawing-side writer.
- Sits between the VGA timing block, which supplies hc/vc, and the RAM.
- Issues display reads one pixel-group ahead, so registered colour outputs feed the VGA block's input_red/green/blue with no gaps.
- Writer uses valid/ready and is granted every RAM cycle that is not a display fetch slot.

Parameters:
- FB_W, 160, framebuffer width in bytes.
- FB_H, 120, framebuffer height in rows.
- ADDR_W, 15, RAM address width; 2^ADDR_W >= FB_W*FB_H.

Ports:
- vgaclk  in  1  pixel clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- hc  in  10  horizontal counter from VGA timing, 0..799.
- vc  in  10  vertical counter from VGA timing, 0..524.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer grant for this cycle.
- wr_addr  in  ADDR_W  writer byte address, row*FB_W+col.
- wr_data  in  8  writer colour, {R[2:0],G[2:0],B[1:0]}.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid 1 cycle after its address.
- pix_red  out  3  registered pixel red.
- pix_green  out  3  registered pixel green.
- pix_blue  out  2  registered pixel blue.

Behaviour:
- Timing constants: 640 visible of 800 per line, 480 visible of 525 lines.
- Fetch slot, fetch_slot=1, when either condition holds:
  - hc[1:0]==2, hc<=634 and vc<480. Target tx=hc+2, ty=vc.
  - hc==798 and next line <480. Next line is vc+1, or 0 when vc==524. Target tx=0, ty=next line.
- There are 160 slots per visible line.
- Fetch address = row_base + (tx>>2).
  - row_base is a registered running sum, not a multiplier.
  - Update at hc==799: set row_base to 0 when the next line is 0; add FB_W when the next line is nonzero and its [1:0]==0; otherwise hold.
- Read pipeline: fetch_slot registers into rd_pend. On a cycle with rd_pend=1, the pix_* regs load mem_rdata at the clock edge. Result: group g (columns 4g..4g+3) is presented on pix_* during hc=4g..4g+3.
- pix_* hold their last value outside fetch loads; blanking is the VGA block's job.
- wr_ready = !rst && !fetch_slot (plus the gate under Optional Feature).
  - Combinational from hc/vc only; never depends on wr_valid.
- Transfer happens when wr_valid && wr_ready:
  - mem_addr=wr_addr, mem_wdata=wr_data.
  - mem_we=1 only if wr_addr < FB_W*FB_H.
  - Out-of-range writes are accepted (handshake completes) and dropped.
- Mux priority: fetch_slot > write > idle. Idle drives mem_addr=0, mem_we=0.
- Collision: when fetch_slot and wr_valid are high together, the writer stalls with wr_ready=0. The writer must hold addr/data stable; at most 1 cycle of stall.
- Reset (synchronous): row_base=0, rd_pend=0, pix_*=0, mem_we=0, wr_ready=0.
- Reset mid-frame: after release, the first correct pixels appear once hc/vc reach line 0 again. Until then, fetches use row_base=0.
- hc/vc jumps, e.g. the timing block being reset independently, are tolerated: row_base resyncs at the next line-0 boundary.

Optional Feature:
- Macro: VGA_FB_VBLANK_WR_EN.
- Defined: wr_ready is additionally gated by vc>=480, so writes land only in vertical blanking (tear-free). Cost: a writer may stall up to ~384,000 cycles.
- Undefined: writes are granted in any non-fetch cycle, including the visible area.

Decomposition:
- Package vga_pkg holds:
  - H_VISIBLE=640, H_TOTAL=800, V_VISIBLE=480, V_TOTAL=525.
  - FB_SCALE_LOG2=2.
  - typedef rgb332_t, a packed struct {r[2:0], g[2:0], b[1:0]}.
- One natural sub-module, vga_fb_addr_gen: computes fetch_slot and the fetch address and owns the row_base register.
- The arbiter keeps the mux, handshake and read pipeline.

Test Plan:
- Reset, then run 2 frames with wr_valid=0 and RAM byte k preloaded with k[7:0] → at vc=0, pix outputs show byte 0 over hc=0..3 and byte 1 over hc=4..7; at vc=4, byte 160 at hc=0.
- wr_valid held high through line 10 → wr_ready=0 at hc=2,6,...,634 and at 798, and 1 elsewhere; exactly 800-160=640 writes complete.
- Write 0xE0 to address 161 in blanking (vc=500) → the next frame shows 0xE0 at vc=4..7, hc=4..7.
- wr_addr=19200 with data 0xFF, accepted → mem_we=0 and RAM unchanged.
- Assert rst at vc=200, hc=300 for 3 cycles → pix_*=0 and wr_ready=0 during reset; the next frame's pixels match the first scenario.
- With VGA_FB_VBLANK_WR_EN defined → wr_ready=0 for all vc<480; the first grant is at vc=480, hc=0.
